an_scan_capture: RTL and testbench
==================================

Name: an_scan_capture

Overview:
- Receive-side counterpart to the AN_SEL anode scanner: observes a multiplexed, active-low 7-segment bus (AN, SEG, DP) and reconstructs the four displayed hex digits.
- Samples each digit only after its anode and segments have been stable for a configurable settle time.
- Decodes the segment pattern back to a nibble and reports frame completion, bad patterns, bad anode codes and a stalled scan.
- Used as a self-check and readback block beside the display driver in the ALU project.

Parameters:
- SETTLE_CYCLES, 4: consecutive cycles {AN,SEG,DP} must be unchanged before a capture; legal range 1..255.
- TIMEOUT_CYCLES, 65535: cycles without a capture before stale asserts; legal range 2..2^20-1.

Ports:
- Clk  in  1  system clock, rising edge
- Reset  in  1  synchronous, active-low reset
- AN  in  4  anode enables, active-low; AN[i]=0 selects digit i
- SEG  in  7  segments {g,f,e,d,c,b,a}, active-low
- DP  in  1  decimal point, active-low
- digits  out  16  captured nibbles; digit i at [4i+3:4i]
- dp_out  out  4  captured DP per digit, active-high
- valid_mask  out  4  digits captured in the current frame
- frame_done  out  1  one-cycle pulse when all four digits are captured
- seg_err  out  1  one-cycle pulse: SEG not in the hex table
- an_err  out  1  one-cycle pulse: stable AN is neither one-hot-low nor 4'b1111
- stale  out  1  level: no capture for TIMEOUT_CYCLES
- sel_out  out  2  index of the last captured digit

Behaviour:
- Reset (Reset=0 at a rising edge):
  - all outputs 0, input registers 0, counters 0, FSM in IDLE.
  - Reset mid-frame discards partial frame state; no frame_done is emitted.
- Input stage: one register on {AN,SEG,DP} (same clock domain). A stability counter clears whenever the registered value differs from the previous cycle, otherwise increments and saturates at SETTLE_CYCLES.
- FSM states: IDLE, SETTLE, CAPTURE, HOLD.
  - IDLE -> SETTLE on any registered-input change.
  - SETTLE -> CAPTURE when the stable count reaches SETTLE_CYCLES. Any change returns the counter to 0 and stays in SETTLE.
  - CAPTURE is a single cycle and classifies the stable value:
    - AN one-hot-low: decode SEG. A valid pattern writes digits[i], dp_out[i]=~DP, sets valid_mask[i] and sel_out=i. An invalid pattern pulses seg_err and leaves digits, mask and sel_out unchanged.
    - AN=4'b1111 (blank slot): no write, no error.
    - any other AN: pulse an_err.
    - Then go to HOLD.
  - HOLD -> SETTLE on the next input change; stays in HOLD otherwise, so there is exactly one capture or error per stable window.
- Latency: with inputs stable from just before rising edge k, outputs update after edge k+SETTLE_CYCLES+1.
- Decode table (gfedcba, hex):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
  - all other patterns, including 7F (blank), are invalid.
- Frame handling:
  - recapturing a digit already in the mask overwrites it; the mask is unchanged.
  - the capture that makes the mask 4'b1111 pulses frame_done in the same cycle the digit updates, and the mask clears to 0 on the following edge.
- Timeout:
  - a 20-bit counter clears on every valid capture, increments otherwise and saturates.
  - stale=1 while count >= TIMEOUT_CYCLES; it drops in the cycle after the next valid capture.
- Simultaneous events: seg_err, an_err and frame_done are mutually exclusive by construction; reset dominates everything.

Decomposition:
- Package seg7_pkg:
  - FSM state enum (2 bits)
  - the 16 active-low segment constants
  - BLANK_SEG = 7'h7F
  - AN_NONE = 4'b1111
- One combinational sub-module seg7_decode: input 7-bit pattern; outputs 4-bit nibble and valid. Shared with the project's encoder checks.

Test Plan:
- Reset: hold Reset=0 for 3 cycles with random AN/SEG -> all outputs 0. Release and hold AN=1111 for 50 cycles -> no pulses, digits=0000.
- Full frame, SETTLE_CYCLES=4, each slot held 8 cycles:
  - drive AN=1110/SEG=0E, AN=1101/SEG=30, AN=1011/SEG=08, AN=0111/SEG=79, DP=1 throughout.
  - expect digits=16'h1A3F, dp_out=0000, sel_out=3, exactly one frame_done pulse, then valid_mask=0000.
- Glitch rejection: from a settled frame, drive AN=1101/SEG=00 for 3 cycles, then revert -> no capture, digits unchanged. Holding it 8 cycles -> digits[7:4]=8 at edge k+5.
- Bad segment: AN=1011/SEG=7F for 8 cycles -> one seg_err pulse, digits[11:8] and valid_mask[2] unchanged.
- Bad anode: AN=1100 stable 10 cycles -> exactly one an_err pulse, no digit write.
- Timeout and reset:
  - with TIMEOUT_CYCLES=32, stop scanning -> stale=1 after 32 cycles without capture; a valid capture clears it.
  - capture 2 digits, pulse Reset -> valid_mask=0, digits=0, no frame_done.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and constants for the active-low 7-segment bus:
// capture FSM states, the hex segment table and the anode select helper.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } cap_state_t;

    // Active-low patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    localparam logic [6:0] BLANK_SEG = 7'h7F;
    localparam logic [3:0] AN_NONE   = 4'b1111;

    typedef struct packed {
        logic       hit;
        logic [1:0] idx;
    } an_sel_t;

    // hit is set only for a one-hot-low anode code.
    function automatic an_sel_t an_decode(input logic [3:0] an);
        an_sel_t r;
        r = '{hit: 1'b0, idx: 2'd0};
        case (an)
            4'b1110: r = '{hit: 1'b1, idx: 2'd0};
            4'b1101: r = '{hit: 1'b1, idx: 2'd1};
            4'b1011: r = '{hit: 1'b1, idx: 2'd2};
            4'b0111: r = '{hit: 1'b1, idx: 2'd3};
            default: r = '{hit: 1'b0, idx: 2'd0};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational inverse of the hex 7-segment encoder; anything outside
// the sixteen hex glyphs (blank included) reports valid=0.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       valid
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        nibble = 4'h0;
        valid  = 1'b1;
        case (seg)
            SEG_0:   nibble = 4'h0;
            SEG_1:   nibble = 4'h1;
            SEG_2:   nibble = 4'h2;
            SEG_3:   nibble = 4'h3;
            SEG_4:   nibble = 4'h4;
            SEG_5:   nibble = 4'h5;
            SEG_6:   nibble = 4'h6;
            SEG_7:   nibble = 4'h7;
            SEG_8:   nibble = 4'h8;
            SEG_9:   nibble = 4'h9;
            SEG_A:   nibble = 4'hA;
            SEG_B:   nibble = 4'hB;
            SEG_C:   nibble = 4'hC;
            SEG_D:   nibble = 4'hD;
            SEG_E:   nibble = 4'hE;
            SEG_F:   nibble = 4'hF;
            default: valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/an_scan_capture.sv
// Observes a multiplexed active-low 7-segment bus and rebuilds the four
// displayed hex digits once each anode slot has been stable long enough.
module an_scan_capture
    import seg7_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [3:0]  AN,
    input  logic [6:0]  SEG,
    input  logic        DP,
    output logic [15:0] digits,
    output logic [3:0]  dp_out,
    output logic [3:0]  valid_mask,
    output logic        frame_done,
    output logic        seg_err,
    output logic        an_err,
    output logic        stale,
    output logic [1:0]  sel_out
);

    localparam logic [7:0]  SETTLE_MAX  = 8'(SETTLE_CYCLES);
    localparam logic [19:0] TIMEOUT_LIM = 20'(TIMEOUT_CYCLES);
    localparam logic [19:0] TMO_SAT     = 20'hFFFFF;

    logic [11:0] bus_q;
    logic [11:0] bus_prev;
    logic [7:0]  stab_cnt;
    logic [7:0]  stab_nxt;
    logic [19:0] tmo_cnt;
    logic [19:0] tmo_nxt;
    cap_state_t  state;

    logic        changed;
    logic        settled;
    logic        write_ok;
    an_sel_t     sel;
    logic [3:0]  nibble;
    logic        seg_ok;
    logic [3:0]  mask_wr;

    seg7_decode u_decode (
        .seg    (bus_q[7:1]),
        .nibble (nibble),
        .valid  (seg_ok)
    );

    always_comb begin
        changed = (bus_q != bus_prev);
        sel     = an_decode(bus_q[11:8]);
        mask_wr = valid_mask | (4'b0001 << sel.idx);

        if (changed)
            stab_nxt = 8'd0;
        else if (stab_cnt < SETTLE_MAX)
            stab_nxt = stab_cnt + 8'd1;
        else
            stab_nxt = stab_cnt;

        // The capture is registered on the same edge the count reaches the
        // settle target, which gives the k+SETTLE_CYCLES+1 latency.
        settled  = (state == SETTLE) && (stab_nxt == SETTLE_MAX);
        write_ok = settled && sel.hit && seg_ok;

        if (write_ok)
            tmo_nxt = 20'd0;
        else if (tmo_cnt != TMO_SAT)
            tmo_nxt = tmo_cnt + 20'd1;
        else
            tmo_nxt = tmo_cnt;
    end

    always_ff @(posedge Clk) begin
        // NOTE: Reset is sampled on the clock edge only; every register, state included, is cleared here.
        if (!Reset) begin
            bus_q      <= '0;
            bus_prev   <= '0;
            stab_cnt   <= '0;
            tmo_cnt    <= '0;
            state      <= IDLE;
            digits     <= '0;
            dp_out     <= '0;
            valid_mask <= '0;
            frame_done <= 1'b0;
            seg_err    <= 1'b0;
            an_err     <= 1'b0;
            stale      <= 1'b0;
            sel_out    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            bus_q      <= {AN, SEG, DP};
            bus_prev   <= bus_q;
            stab_cnt   <= stab_nxt;
            tmo_cnt    <= tmo_nxt;
            stale      <= (tmo_nxt >= TIMEOUT_LIM);
            frame_done <= 1'b0;
            seg_err    <= 1'b0;
            an_err     <= 1'b0;

            case (state)
                IDLE: begin
                    if (changed)
                        state <= SETTLE;
                end
                SETTLE: begin
                    if (settled) begin
                        state <= CAPTURE;
                        if (sel.hit) begin
                            if (seg_ok) begin
                                digits[{sel.idx, 2'b00} +: 4] <= nibble;
                                dp_out[sel.idx]               <= ~bus_q[0];
                                sel_out                       <= sel.idx;
                                valid_mask                    <= mask_wr;
                                frame_done                    <= &mask_wr;
                            end else begin
                                seg_err <= 1'b1;
                            end
                        end else if (bus_q[11:8] != AN_NONE) begin
                            an_err <= 1'b1;
                        end
                    end
                end
                CAPTURE: begin
                    if (frame_done)
                        valid_mask <= 4'b0000;
                    // A change seen here must still open a new window.
                    state <= changed ? SETTLE : HOLD;
                end
                HOLD: begin
                    if (changed)
                        state <= SETTLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_an_scan_capture.sv
// Directed bench for an_scan_capture: a run-length bus model predicts every
// output each cycle, and literal checks pin the model at key points.
module tb_an_scan_capture;

    localparam int SETTLE = 4;
    localparam int TMO    = 32;

    logic        Clk   = 1'b0;
    logic        Reset = 1'b0;
    logic [3:0]  AN    = 4'h0;
    logic [6:0]  SEG   = 7'h00;
    logic        DP    = 1'b0;
    logic [15:0] digits;
    logic [3:0]  dp_out;
    logic [3:0]  valid_mask;
    logic        frame_done;
    logic        seg_err;
    logic        an_err;
    logic        stale;
    logic [1:0]  sel_out;

    always #5 Clk = ~Clk;

    an_scan_capture #(
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .AN         (AN),
        .SEG        (SEG),
        .DP         (DP),
        .digits     (digits),
        .dp_out     (dp_out),
        .valid_mask (valid_mask),
        .frame_done (frame_done),
        .seg_err    (seg_err),
        .an_err     (an_err),
        .stale      (stale),
        .sel_out    (sel_out)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Hex glyph table, index = nibble.
    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Model: a capture happens when the bus held one value for exactly
    // SETTLE+1 samples, that run having begun with a change.
    logic [11:0] m_last;
    int          m_run;
    int          m_tmo;
    logic [15:0] m_digits;
    logic [3:0]  m_dp, m_mask;
    logic        m_frame, m_seg, m_an, m_stale;
    logic [1:0]  m_sel;
    bit          m_started = 1'b0;
    bit          m_cap;
    bit          m_found;
    int          m_idx;
    logic [3:0]  m_nib;

    always @(posedge Clk) begin
        if (!Reset) begin
            m_last = '0; m_run = 0; m_tmo = 0;
            m_digits = '0; m_dp = '0; m_mask = '0; m_sel = '0;
            m_frame = 1'b0; m_seg = 1'b0; m_an = 1'b0; m_stale = 1'b0;
        end else begin
            m_cap = 1'b0;
            if (m_frame) m_mask = 4'h0;
            m_frame = 1'b0; m_seg = 1'b0; m_an = 1'b0;
            if (m_run == SETTLE + 1) begin
                if ($countones(~m_last[11:8]) == 1) begin
                    m_idx = 0;
                    for (int n = 0; n < 4; n++) if (!m_last[8 + n]) m_idx = n;
                    m_found = 1'b0;
                    m_nib   = 4'h0;
                    for (int n = 0; n < 16; n++)
                        if (seg_tab[n] == m_last[7:1]) begin m_found = 1'b1; m_nib = 4'(n); end
                    if (m_found) begin
                        m_digits[m_idx*4 +: 4] = m_nib;
                        m_dp[m_idx]   = ~m_last[0];
                        m_mask[m_idx] = 1'b1;
                        m_sel = 2'(m_idx);
                        m_cap = 1'b1;
                        if (m_mask == 4'hF) m_frame = 1'b1;
                    end else begin
                        m_seg = 1'b1;
                    end
                end else if (m_last[11:8] != 4'hF) begin
                    m_an = 1'b1;
                end
            end
            if (m_cap) m_tmo = 0;
            else if (m_tmo < 1048575) m_tmo = m_tmo + 1;
            m_stale = (m_tmo >= TMO);
            if ({AN, SEG, DP} != m_last) begin
                m_last = {AN, SEG, DP};
                m_run  = 1;
            end else if (m_run != 0 && m_run < 1000) begin
                m_run = m_run + 1;
            end
        end
        m_started = 1'b1;
    end

    always @(negedge Clk) begin
        if (m_started) begin
            check("digits",     32'(digits),     32'(m_digits));
            check("dp_out",     32'(dp_out),     32'(m_dp));
            check("valid_mask", 32'(valid_mask), 32'(m_mask));
            check("frame_done", 32'(frame_done), 32'(m_frame));
            check("seg_err",    32'(seg_err),    32'(m_seg));
            check("an_err",     32'(an_err),     32'(m_an));
            check("stale",      32'(stale),      32'(m_stale));
            check("sel_out",    32'(sel_out),    32'(m_sel));
        end
    end

    // Pulse counters sample the pre-edge value, i.e. the previous cycle.
    int n_frame = 0, n_seg = 0, n_an = 0;
    always @(posedge Clk) begin
        if (m_started) begin
            if (frame_done === 1'b1) n_frame++;
            if (seg_err === 1'b1)    n_seg++;
            if (an_err === 1'b1)     n_an++;
        end
    end

    task automatic drive(input logic [3:0] an, input logic [6:0] seg, input logic dp, input int n);
        AN = an; SEG = seg; DP = dp;
        repeat (n) @(negedge Clk);
    endtask

    int f0, s0, a0;

    initial begin
        repeat (3) begin
            AN = 4'($urandom); SEG = 7'($urandom); DP = 1'($urandom);
            @(negedge Clk);
        end
        check("reset_outputs", 32'({digits, dp_out, valid_mask, frame_done, seg_err, an_err, stale, sel_out}), 32'd0);

        f0 = n_frame; s0 = n_seg; a0 = n_an;
        Reset = 1'b1;
        drive(4'b1111, 7'h7F, 1'b1, 50);
        check("blank_pulses", 32'((n_frame - f0) + (n_seg - s0) + (n_an - a0)), 32'd0);
        check("blank_digits", 32'(digits), 32'h0000);
        check("blank_stale",  32'(stale),  32'd1);

        f0 = n_frame;
        drive(4'b1110, 7'h0E, 1'b1, 8);
        drive(4'b1101, 7'h30, 1'b1, 8);
        drive(4'b1011, 7'h08, 1'b1, 8);
        drive(4'b0111, 7'h79, 1'b1, 8);
        check("frame_digits", 32'(digits),     32'h1A3F);
        check("frame_dp",     32'(dp_out),     32'd0);
        check("frame_sel",    32'(sel_out),    32'd3);
        check("frame_mask",   32'(valid_mask), 32'd0);
        check("frame_pulses", 32'(n_frame - f0), 32'd1);
        check("frame_stale",  32'(stale),      32'd0);

        drive(4'b1101, 7'h00, 1'b1, 3);
        drive(4'b0111, 7'h79, 1'b1, 8);
        check("glitch_digits", 32'(digits), 32'h1A3F);

        AN = 4'b1101; SEG = 7'h00; DP = 1'b1;
        repeat (5) @(posedge Clk);
        @(negedge Clk);
        check("latency_k4", 32'(digits[7:4]), 32'd3);
        @(posedge Clk);
        @(negedge Clk);
        check("latency_k5", 32'(digits[7:4]), 32'd8);
        repeat (2) @(negedge Clk);

        s0 = n_seg;
        drive(4'b1011, 7'h7F, 1'b1, 8);
        check("segerr_pulses", 32'(n_seg - s0),  32'd1);
        check("segerr_digit",  32'(digits[11:8]), 32'hA);
        check("segerr_mask",   32'(valid_mask),   32'b1010);

        a0 = n_an;
        drive(4'b1100, 7'h00, 1'b1, 10);
        check("anerr_pulses", 32'(n_an - a0), 32'd1);
        check("anerr_digits", 32'(digits),    32'h1A8F);

        drive(4'b1111, 7'h7F, 1'b1, 40);
        check("timeout_stale", 32'(stale), 32'd1);
        drive(4'b1110, 7'h40, 1'b0, 8);
        check("recover_stale",  32'(stale),      32'd0);
        check("recover_digits", 32'(digits),     32'h1A80);
        check("recover_dp",     32'(dp_out),     32'b0001);
        check("recover_mask",   32'(valid_mask), 32'b1011);

        f0 = n_frame;
        drive(4'b1101, 7'h19, 1'b1, 8);
        check("pre_reset_digits", 32'(digits), 32'h1A40);
        AN = 4'b1011; SEG = 7'h24; DP = 1'b1;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        check("midreset_mask",   32'(valid_mask), 32'd0);
        check("midreset_digits", 32'(digits),     32'd0);
        Reset = 1'b1;
        drive(4'b1111, 7'h7F, 1'b1, 10);
        check("midreset_frame",  32'(n_frame - f0), 32'd0);
        check("post_reset_digits", 32'(digits),    32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
